bcd_to_binary: RTL

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary
//   Sequential 9-digit BCD to 30-bit binary converter. It uses the
//   reverse double-dabble method. The BCD word is placed at the top of a
//   66-bit work register. Each iteration shifts the register right by one
//   bit and then subtracts 3 from every BCD nibble that is >= 8. After 30
//   iterations the binary result sits in work[29:0].
//
//   Ports
//     sys_clk    in   clock, rising edge
//     sys_rst_n  in   asynchronous active-low reset
//     start      in   conversion request; ignored while busy
//     bcd_data   in   [35:0] 9 packed BCD digits, digit 0 in [3:0]
//     busy       out  high from start acceptance until the result edge
//     done       out  one-cycle pulse, data/bcd_err valid from this cycle
//     data       out  [29:0] binary result, held until the next done
//     bcd_err    out  last accepted input had a digit > 9, held until next done
// ---------------------------------------------------------------------------

// Per-nibble correction applied after each right shift. The arithmetic is
// 4 bits wide, so no borrow can leak into the neighbouring digit.
module bcd_to_binary_nib_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;
endmodule

module bcd_to_binary #(
    parameter logic [6:0] CNT_SHIFT_NUM = 7'd30
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [35:0] bcd_data,
    output logic        busy,
    output logic        done,
    output logic [29:0] data,
    output logic        bcd_err
);

    localparam int NDIG  = 9;
    localparam int BIN_W = 30;
    localparam int WRK_W = 4 * NDIG + BIN_W;   // 66

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [WRK_W-1:0]          work_q,  work_d;
    logic [6:0]                cnt_q,   cnt_d;
    logic                      err_q,   err_d;     // in-flight conversion was rejected
    logic [BIN_W-1:0]          data_q,  data_d;
    logic                      busy_q,  busy_d;
    logic                      done_q,  done_d;
    logic                      bcd_err_q, bcd_err_d;

    logic [NDIG-1:0][3:0]      adj_bcd;
    logic                      digit_bad;

    // All nine BCD nibbles of the work register are corrected in parallel.
    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_adj
            bcd_to_binary_nib_adj u_nib_adj (
                .nib_i (work_q[BIN_W + 4*g +: 4]),
                .nib_o (adj_bcd[g])
            );
        end
    endgenerate

    // Any digit above 9 rejects the request before any iteration runs.
    always_comb begin
        digit_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_data[4*k +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_err_d = bcd_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (digit_bad) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        // The input is captured here only. Later changes
                        // on bcd_data do not affect this conversion.
                        err_d   = 1'b0;
                        work_d  = {bcd_data, {BIN_W{1'b0}}};
                        cnt_d   = 7'd0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                work_d  = {1'b0, work_q[WRK_W-1:1]};
                cnt_d   = cnt_q + 7'd1;
                state_d = ADJ;
            end

            ADJ: begin
                // The counter already holds the number of completed shifts.
                // The correction after the final shift touches only the
                // (by then zero) BCD field, so it is harmless.
                work_d  = {adj_bcd, work_q[BIN_W-1:0]};
                state_d = (cnt_q < CNT_SHIFT_NUM) ? SHIFT : FIN;
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (err_q) begin
                    data_d    = '0;
                    bcd_err_d = 1'b1;
                end else begin
                    data_d    = work_q[BIN_W-1:0];
                    bcd_err_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign data    = data_q;
    assign bcd_err = bcd_err_q;

endmodule
